// File: rtl/ping_sequencer_if.sv
// Control and sample-stream bundle for ping_sequencer: start/abort/lengths,
// transmit sample handshake, received sample strobe and status.
interface ping_sequencer_if #(
  parameter int DAC_BITS = 16,
  parameter int ADC_BITS = 12,
  parameter int LEN_W    = 16
);
  logic                start;
  logic                abort;
  logic [LEN_W-1:0]    tx_len;
  logic [LEN_W-1:0]    rx_len;
  logic [DAC_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [ADC_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                busy;
  logic                done;

  modport master (
    output start, abort, tx_len, rx_len, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, abort, tx_len, rx_len, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, done
  );
endinterface

// File: rtl/ping_sequencer.sv
// One transmit/receive ping: DAC burst with transmit_enable, guard, then ADC conversions.
// Optional macro PING_UNDERRUN_FILL_EN: send midscale instead of stalling on tx underrun.
module ping_sequencer #(
  parameter int DAC_BITS     = 16,
  parameter int ADC_FRAME    = 16,
  parameter int ADC_BITS     = 12,
  parameter int GUARD_CYCLES = 96,
  parameter int LEN_W        = 16
) (
  input  logic clk48,
  input  logic reset,
  ping_sequencer_if.slave ctl,
  output logic transmit_enable,
  output logic dac_cs,
  output logic dac_sdi,
  output logic adc_cs,
  input  logic adc_sdo
`ifdef PING_UNDERRUN_FILL_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, TX_LOAD, TX_SHIFT, GUARD, RX_SHIFT, RX_GAP, DONE
  } state_t;

  localparam int M1      = (DAC_BITS > ADC_FRAME) ? DAC_BITS : ADC_FRAME;
  localparam int CYC_MAX = (M1 > GUARD_CYCLES) ? M1 : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CYC_MAX + 1);

  localparam logic [CNT_W-1:0] DAC_LAST   = CNT_W'(DAC_BITS - 1);
  localparam logic [CNT_W-1:0] ADC_LAST   = CNT_W'(ADC_FRAME - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_t              state, state_nxt, post_tx;
  logic [CNT_W-1:0]    cyc_cnt;
  logic [LEN_W-1:0]    tx_cnt, rx_cnt, tx_cnt_inc, rx_cnt_inc;
  logic [LEN_W-1:0]    tx_len_q, rx_len_q;
  logic [DAC_BITS-1:0] tx_sh;
  logic [ADC_BITS-1:0] rx_sh, rx_data_q, rx_word;
  logic                tx_ready, rx_valid, busy, done;
  logic                abort_hit;

`ifdef PING_UNDERRUN_FILL_EN
  localparam logic [DAC_BITS-1:0] MIDSCALE = {1'b1, {(DAC_BITS-1){1'b0}}};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign tx_cnt_inc = tx_cnt + LEN_W'(1);
  assign rx_cnt_inc = rx_cnt + LEN_W'(1);
  assign rx_word    = {rx_sh[ADC_BITS-2:0], adc_sdo};
  assign abort_hit  = ctl.abort && (state != IDLE);

  assign ctl.tx_ready = tx_ready;
  assign ctl.rx_valid = rx_valid;
  assign ctl.rx_data  = rx_data_q;
  assign ctl.busy     = busy;
  assign ctl.done     = done;

  always_ff @(posedge clk48) begin
    if (reset || abort_hit) state <= IDLE;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    post_tx         = DONE;
    tx_ready        = 1'b0;
    rx_valid        = 1'b0;
    busy            = (state != IDLE);
    done            = 1'b0;
    transmit_enable = 1'b0;
    dac_cs          = 1'b1;
    dac_sdi         = 1'b0;
    adc_cs          = 1'b1;

    if (GUARD_CYCLES != 0)   post_tx = GUARD;
    else if (rx_len_q != '0) post_tx = RX_SHIFT;

    case (state)
      IDLE: begin
        if (ctl.start) begin
          if (ctl.tx_len != '0)                           state_nxt = TX_LOAD;
          else if (ctl.rx_len != '0 && GUARD_CYCLES != 0) state_nxt = GUARD;
          else if (ctl.rx_len != '0)                      state_nxt = RX_SHIFT;
          else                                            state_nxt = DONE;
        end
      end
      TX_LOAD: begin
        tx_ready        = 1'b1;
        transmit_enable = 1'b1;
`ifdef PING_UNDERRUN_FILL_EN
        state_nxt = TX_SHIFT;
`else
        if (ctl.tx_valid) state_nxt = TX_SHIFT;
`endif
      end
      TX_SHIFT: begin
        transmit_enable = 1'b1;
        dac_cs          = 1'b0;
        dac_sdi         = tx_sh[DAC_BITS-1];
        if (cyc_cnt == DAC_LAST) state_nxt = (tx_cnt_inc == tx_len_q) ? post_tx : TX_LOAD;
      end
      GUARD: begin
        if (cyc_cnt == GUARD_LAST) state_nxt = (rx_len_q != '0) ? RX_SHIFT : DONE;
      end
      RX_SHIFT: begin
        adc_cs = 1'b0;
        if (cyc_cnt == ADC_LAST) state_nxt = RX_GAP;
      end
      RX_GAP: begin
        rx_valid  = 1'b1;
        state_nxt = (rx_cnt_inc == rx_len_q) ? DONE : RX_SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control counters and the visible sample register
  always_ff @(posedge clk48) begin
    if (reset || abort_hit) begin
      cyc_cnt   <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      rx_data_q <= '0;
`ifdef PING_UNDERRUN_FILL_EN
      if (reset) underrun_count <= '0;
`endif
    end else begin
      cyc_cnt <= (state_nxt != state) ? '0 : cyc_cnt + CNT_W'(1);
      if (state == IDLE && ctl.start) begin
        tx_cnt <= '0;
        rx_cnt <= '0;
`ifdef PING_UNDERRUN_FILL_EN
        underrun_count <= '0;
`endif
      end
`ifdef PING_UNDERRUN_FILL_EN
      if (state == TX_LOAD && !ctl.tx_valid) underrun_count <= sat_inc(underrun_count);
`endif
      if (state == TX_SHIFT && cyc_cnt == DAC_LAST) tx_cnt <= tx_cnt_inc;
      if (state == RX_SHIFT && cyc_cnt == ADC_LAST) rx_data_q <= rx_word;
      if (state == RX_GAP) rx_cnt <= rx_cnt_inc;
    end
  end

  // Shift registers and latched lengths
  always_ff @(posedge clk48) begin
    if (state == IDLE && ctl.start) begin
      tx_len_q <= ctl.tx_len;
      rx_len_q <= ctl.rx_len;
    end
    if (state == TX_LOAD) begin
`ifdef PING_UNDERRUN_FILL_EN
      tx_sh <= ctl.tx_valid ? ctl.tx_data : MIDSCALE;
`else
      if (ctl.tx_valid) tx_sh <= ctl.tx_data;
`endif
    end else if (state == TX_SHIFT) begin
      tx_sh <= {tx_sh[DAC_BITS-2:0], 1'b0};
    end
    if (state == RX_SHIFT) rx_sh <= rx_word;
  end

endmodule

// File: tb/tb_ping_sequencer.sv
// Directed bench for ping_sequencer with an ADC pin model and a pin monitor.
module tb_ping_sequencer;
  logic clk48 = 1'b0;
  logic reset;
  logic transmit_enable, dac_cs, dac_sdi, adc_cs;
  logic adc_sdo = 1'b0;
`ifdef PING_UNDERRUN_FILL_EN
  logic [15:0] underrun_count;
`endif

  ping_sequencer_if #(.DAC_BITS(16), .ADC_BITS(12), .LEN_W(16)) ifc ();

  ping_sequencer dut (
    .clk48          (clk48),
    .reset          (reset),
    .ctl            (ifc),
    .transmit_enable(transmit_enable),
    .dac_cs         (dac_cs),
    .dac_sdi        (dac_sdi),
    .adc_cs         (adc_cs),
    .adc_sdo        (adc_sdo)
`ifdef PING_UNDERRUN_FILL_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk48 = ~clk48;

  int tests = 0;
  int fails = 0;

  logic [15:0] tx_words [8];
  int          tx_idx;
  logic        mon_clr;
  logic [15:0] adc_pat = 16'h0B3C;

  assign ifc.tx_data = tx_words[tx_idx[2:0]];

  always @(posedge clk48) begin
    if (mon_clr)                            tx_idx <= 0;
    else if (ifc.tx_valid && ifc.tx_ready)  tx_idx <= tx_idx + 1;
  end

  // ADC model: next frame bit presented on the falling edge while adc_cs is low
  int adc_k = 0;
  always @(negedge clk48) begin
    if (!adc_cs) begin
      adc_sdo = (adc_k < 16) ? adc_pat[15 - adc_k] : 1'b0;
      adc_k++;
    end else begin
      adc_k   = 0;
      adc_sdo = 1'b0;
    end
  end

  // Pin monitor
  int dac_nf, dac_nbits, dac_len_bad, dac_gapcnt, gap1;
  logic [15:0] dac_word;
  logic [15:0] dac_fr [8];
  int adc_nf, adc_nbits, adc_len_bad;
  int rx_cnt, rx_bad;
  logic [11:0] rx_last;
  int done_cnt, busy_cnt, guard_cnt, inv_bad, cs_act, te_cnt, te_fall_ok, te_fall_bad;
  logic p_dac_cs, p_adc_cs, p_te;

  always @(negedge clk48) begin
    if (mon_clr) begin
      dac_nf = 0; dac_nbits = 0; dac_len_bad = 0; dac_gapcnt = 0; gap1 = -1; dac_word = '0;
      for (int i = 0; i < 8; i++) dac_fr[i] = '0;
      adc_nf = 0; adc_nbits = 0; adc_len_bad = 0; rx_cnt = 0; rx_bad = 0; rx_last = '0;
      done_cnt = 0; busy_cnt = 0; guard_cnt = 0; inv_bad = 0; cs_act = 0; te_cnt = 0;
      te_fall_ok = 0; te_fall_bad = 0;
      p_dac_cs = 1'b1; p_adc_cs = 1'b1; p_te = 1'b0;
    end else begin
      if (!dac_cs) begin
        dac_word = {dac_word[14:0], dac_sdi};
        dac_nbits++;
        cs_act++;
        if (p_dac_cs && dac_nf == 1) gap1 = dac_gapcnt;
      end else if (!p_dac_cs) begin
        if (dac_nf < 8) dac_fr[dac_nf] = dac_word;
        if (dac_nbits != 16) dac_len_bad++;
        dac_nf++;
        dac_nbits  = 0;
        dac_gapcnt = 1;
      end else begin
        dac_gapcnt++;
      end
      if (!adc_cs) begin
        adc_nbits++;
        cs_act++;
      end else if (!p_adc_cs) begin
        if (adc_nbits != 16) adc_len_bad++;
        adc_nf++;
        adc_nbits = 0;
      end
      if (ifc.rx_valid) begin
        rx_cnt++;
        rx_last = ifc.rx_data;
        if (!(adc_cs && !p_adc_cs)) rx_bad++;
      end
      if (ifc.done) done_cnt++;
      if (ifc.busy) busy_cnt++;
      if (transmit_enable) te_cnt++;
      if (p_te && !transmit_enable) begin
        if (dac_cs && !p_dac_cs) te_fall_ok++;
        else                     te_fall_bad++;
      end
      if (ifc.busy && !transmit_enable && adc_cs && dac_cs && adc_nf == 0 && !ifc.done) guard_cnt++;
      if ((!dac_cs && !adc_cs) || (transmit_enable && !adc_cs)) inv_bad++;
      p_dac_cs = dac_cs;
      p_adc_cs = adc_cs;
      p_te     = transmit_enable;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {12'h0, ifc.tx_ready, ifc.rx_valid, ifc.rx_data, ifc.busy, ifc.done,
                transmit_enable, dac_cs, dac_sdi, adc_cs},
               {12'h0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
  endtask

  // sel: 0 done, 1 adc_cs low, 2 dac_cs low, 3 tx_ready
  task automatic wait_for(input int sel, input int max, input string tag);
    int  n = 0;
    bit  hit = 0;
    while (!hit && n < max) begin
      @(negedge clk48);
      n++;
      case (sel)
        0:       hit = (ifc.done === 1'b1);
        1:       hit = (adc_cs === 1'b0);
        2:       hit = (dac_cs === 1'b0);
        default: hit = (ifc.tx_ready === 1'b1);
      endcase
    end
    check(tag, {31'h0, hit}, 32'h1);
  endtask

  task automatic clear_mon();
    @(posedge clk48); #1 mon_clr = 1'b1;
    @(posedge clk48); #1 mon_clr = 1'b0;
  endtask

  task automatic start_ping(input logic [15:0] tl, input logic [15:0] rl);
    @(posedge clk48); #1;
    ifc.tx_len = tl;
    ifc.rx_len = rl;
    ifc.start  = 1'b1;
    @(posedge clk48); #1 ifc.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    mon_clr      = 1'b1;
    ifc.start    = 1'b0;
    ifc.abort    = 1'b0;
    ifc.tx_len   = '0;
    ifc.rx_len   = '0;
    ifc.tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) tx_words[i] = '0;
    tx_words[0] = 16'hA5F0;
    tx_words[1] = 16'h0001;
    repeat (3) @(posedge clk48);
    #1 reset = 1'b0; mon_clr = 1'b0;
    @(negedge clk48);
    check_reset_vals("reset_values");

    // Full ping: two DAC samples, guard, three ADC frames
    clear_mon();
    start_ping(16'd2, 16'd3);
    wait_for(0, 1000, "t1_done_seen");
    @(negedge clk48);
    check("t1_busy_after_done", {31'h0, ifc.busy}, 32'h0);
    check("t1_done_after_done", {31'h0, ifc.done}, 32'h0);
    @(posedge clk48); #1;
    check("t1_dac_frames",  dac_nf, 2);
    check("t1_dac_word0",   dac_fr[0], 16'hA5F0);
    check("t1_dac_word1",   dac_fr[1], 16'h0001);
    check("t1_dac_len_bad", dac_len_bad, 0);
    check("t1_dac_gap",     gap1, 1);
    check("t1_te_fall_ok",  te_fall_ok, 1);
    check("t1_te_fall_bad", te_fall_bad, 0);
    check("t1_guard_cnt",   guard_cnt, 96);
    check("t1_adc_frames",  adc_nf, 3);
    check("t1_adc_len_bad", adc_len_bad, 0);
    check("t1_done_cnt",    done_cnt, 1);
    check("t1_rx_strobes",  rx_cnt, 3);
    check("t1_rx_data",     rx_last, 12'hB3C);
    check("t1_rx_bad",      rx_bad, 0);
    check("t1_invariants",  inv_bad, 0);
`ifdef PING_UNDERRUN_FILL_EN
    check("t1_underrun", underrun_count, 16'd0);
`endif

    // Abort while idle leaves the held sample alone
    @(posedge clk48); #1 ifc.abort = 1'b1;
    @(posedge clk48); #1 ifc.abort = 1'b0;
    @(negedge clk48);
    check("idle_abort_rx_data", ifc.rx_data, 12'hB3C);
    check("idle_abort_busy",    {31'h0, ifc.busy}, 32'h0);

    // Empty ping: straight to DONE
    clear_mon();
    start_ping(16'd0, 16'd0);
    @(negedge clk48);
    check("t3_done_pulse", {30'h0, ifc.done, ifc.busy}, 32'h3);
    @(negedge clk48);
    check("t3_after", {30'h0, ifc.done, ifc.busy}, 32'h0);
    repeat (3) @(posedge clk48); #1;
    check("t3_busy_cycles", busy_cnt, 1);
    check("t3_done_cnt",    done_cnt, 1);
    check("t3_cs_activity", cs_act, 0);
    check("t3_te_cycles",   te_cnt, 0);

    // Underrun on the second sample
    tx_words[0] = 16'h5A5A;
    tx_words[1] = 16'h0F0F;
    clear_mon();
    start_ping(16'd2, 16'd1);
    wait_for(3, 10, "t4_first_ready");
    @(posedge clk48); #1 ifc.tx_valid = 1'b0;
`ifndef PING_UNDERRUN_FILL_EN
    begin
      int stall_bad = 0;
      wait_for(3, 40, "t4_second_ready");
      for (int i = 0; i < 10; i++) begin
        if (i > 0) @(negedge clk48);
        if (!(dac_cs === 1'b1 && transmit_enable === 1'b1 && ifc.tx_ready === 1'b1)) stall_bad++;
      end
      check("t4_stall_hold", stall_bad, 0);
    end
    @(posedge clk48); #1 ifc.tx_valid = 1'b1;
`endif
    wait_for(0, 1000, "t4_done_seen");
    @(posedge clk48); #1 ifc.tx_valid = 1'b1;
    check("t4_dac_frames", dac_nf, 2);
    check("t4_dac_word0",  dac_fr[0], 16'h5A5A);
`ifdef PING_UNDERRUN_FILL_EN
    check("t4_dac_word1",  dac_fr[1], 16'h8000);
    check("t4_underrun",   underrun_count, 16'd1);
`else
    check("t4_dac_word1",  dac_fr[1], 16'h0F0F);
`endif
    check("t4_dac_len_bad", dac_len_bad, 0);
    check("t4_invariants",  inv_bad, 0);

    // Abort during the 8th bit of the first ADC frame
    tx_words[0] = 16'h1234;
    clear_mon();
    start_ping(16'd1, 16'd2);
    wait_for(1, 400, "t5_adc_low");
    repeat (7) @(negedge clk48);
    ifc.abort = 1'b1;
    @(posedge clk48); #1 ifc.abort = 1'b0;
    @(negedge clk48);
    check_reset_vals("t5_abort_values");
    repeat (40) @(posedge clk48); #1;
    check("t5_no_done", done_cnt, 0);
    check("t5_no_rx",   rx_cnt, 0);
    clear_mon();
    start_ping(16'd1, 16'd1);
    wait_for(0, 1000, "t5_rerun_done");
    @(posedge clk48); #1;
    check("t5_rerun_word",   dac_fr[0], 16'h1234);
    check("t5_rerun_rx",     rx_last, 12'hB3C);
    check("t5_rerun_rx_cnt", rx_cnt, 1);
    check("t5_rerun_done_n", done_cnt, 1);

    // Reset during TX_SHIFT, then a start issued while busy
    tx_words[0] = 16'hC3C3;
    clear_mon();
    start_ping(16'd1, 16'd1);
    wait_for(2, 20, "t6_dac_low");
    repeat (4) @(negedge clk48);
    reset = 1'b1;
    @(posedge clk48); #1 reset = 1'b0;
    @(negedge clk48);
    check_reset_vals("t6_reset_values");
    clear_mon();
    start_ping(16'd1, 16'd1);
    wait_for(1, 400, "t6_adc_low");
    start_ping(16'd1, 16'd1);
    wait_for(0, 1000, "t6_done_seen");
    repeat (40) @(posedge clk48); #1;
    check("t6_done_cnt",   done_cnt, 1);
    check("t6_dac_frames", dac_nf, 1);
    check("t6_dac_word",   dac_fr[0], 16'hC3C3);
    check("t6_adc_frames", adc_nf, 1);
    check("t6_busy_end",   {31'h0, ifc.busy}, 32'h0);
    check("t6_invariants", inv_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
